// File: rtl/seq_pkg.sv
// Shared definitions for the colour-sequence playback stage: FSM states,
// colour codes and sizing constants used by the player and its timer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int COLOUR_W  = 2;
    localparam int MAX_STEPS = 16;
    localparam int STEP_W    = 4;
    localparam int LEN_W     = 5;
    localparam int DATA_W    = COLOUR_W * MAX_STEPS;

    // Colour codes as packed in the pattern word (shared with the input decoder)
    localparam logic [COLOUR_W-1:0] RED    = 2'd0;
    localparam logic [COLOUR_W-1:0] GREEN  = 2'd1;
    localparam logic [COLOUR_W-1:0] BLUE   = 2'd2;
    localparam logic [COLOUR_W-1:0] YELLOW = 2'd3;

    // Requested lengths above the pattern capacity play the whole pattern
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_STEPS)) ? LEN_W'(MAX_STEPS) : len;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Down-counter used to time the lit and dark phases of each step.
// A load overrides counting; the count parks at zero until reloaded.
module seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_SEQ,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge clk) begin
        if (rst_SEQ) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_player.sv
// Plays the first seq_len 2-bit colours of a snapshotted pattern word on the
// LED driver, each lit for ON_CYCLES then dark for OFF_CYCLES, and pulses
// done after the last gap. Outputs are registered from the state register,
// so they trail the state by one cycle, except that abort darkens them at
// the same edge that returns the FSM to IDLE.
module seq_player
    import seq_pkg::*;
#(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500,
    parameter int CNT_W      = 24
) (
    input  logic                clk,
    input  logic                rst_SEQ,
    input  logic                start,
    input  logic                abort,
    input  logic [LEN_W-1:0]    seq_len,
    input  logic [DATA_W-1:0]   seq_data,
    output logic                led_on,
    output logic [COLOUR_W-1:0] led_colour,
    output logic [STEP_W-1:0]   step_idx,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

    // FSM state and snapshots
    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [LEN_W-1:0]    r_len;
    logic [STEP_W-1:0]   r_step;

    // Registered outputs
    logic                r_led_on;
    logic [COLOUR_W-1:0] r_led_colour;
    logic [STEP_W-1:0]   r_step_idx;
    logic                r_busy;
    logic                r_done;

    // Combinational helpers
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_running;
    logic                w_abort_run;
    logic                w_last;
    logic [COLOUR_W-1:0] w_colour;
    logic                w_timer_zero;
    logic                w_timer_load;
    logic [CNT_W-1:0]    w_timer_val;

    assign w_len_clamped = clamp_len(seq_len);
    assign w_running     = (r_state == ON) || (r_state == OFF);
    assign w_abort_run   = abort && w_running;
    assign w_last        = ({1'b0, r_step} == (r_len - LEN_W'(1)));
    assign w_colour      = r_data[{r_step, 1'b0} +: COLOUR_W];

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_SEQ    (rst_SEQ),
        .i_en       (w_running),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_timer_zero)
    );

    // Timer reload requests, aligned with the FSM transitions below
    always_comb begin
        w_timer_load = 1'b0;
        w_timer_val  = '0;
        case (r_state)
            IDLE: begin
                if (start && (w_len_clamped != '0)) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = ON_LOAD;
                end
            end
            ON: begin
                if (abort) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = '0;
                end else if (w_timer_zero) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = OFF_LOAD;
                end
            end
            OFF: begin
                if (abort) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = '0;
                end else if (w_timer_zero && !w_last) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = ON_LOAD;
                end
            end
            default: begin
                w_timer_load = 1'b0;
                w_timer_val  = '0;
            end
        endcase
    end

    // Playback FSM with snapshots and registered LED/status outputs
    always_ff @(posedge clk) begin
        if (rst_SEQ) begin
            r_state      <= IDLE;
            r_data       <= '0;
            r_len        <= '0;
            r_step       <= '0;
            r_led_on     <= 1'b0;
            r_led_colour <= '0;
            r_step_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_led_on     <= (r_state == ON) && !abort;
            r_led_colour <= ((r_state == ON) && !abort) ? w_colour : '0;
            r_step_idx   <= r_step;
            r_busy       <= (r_state != IDLE) && !w_abort_run;
            r_done       <= (r_state == DONE);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data  <= seq_data;
                        r_len   <= w_len_clamped;
                        r_step  <= '0;
                        r_state <= (w_len_clamped == '0) ? DONE : ON;
                    end
                end
                ON: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_timer_zero) begin
                        r_state <= OFF;
                    end
                end
                OFF: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_timer_zero) begin
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_step  <= r_step + STEP_W'(1);
                            r_state <= ON;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign led_on     = r_led_on;
    assign led_colour = r_led_colour;
    assign step_idx   = r_step_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player with ON_CYCLES=4, OFF_CYCLES=2.
// A timeline model predicts every output from the start edge number, the
// clamped length and the captured pattern; abort and reset cut it short.
module tb_seq_player;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;
    localparam int PER   = ON_C + OFF_C;

    logic        clk = 1'b0;
    logic        rst_SEQ = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  seq_len = '0;
    logic [31:0] seq_data = '0;
    logic        led_on;
    logic [1:0]  led_colour;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state
    bit          m_play = 0;
    int          m_k    = 0;
    int          m_len  = 0;
    logic [31:0] m_data = '0;
    int          m_hold = 0;

    seq_player #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_SEQ    (rst_SEQ),
        .start      (start),
        .abort      (abort),
        .seq_len    (seq_len),
        .seq_data   (seq_data),
        .led_on     (led_on),
        .led_colour (led_colour),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    // Advance one clock edge, update the model with the inputs sampled at
    // that edge, then compare every output against the prediction.
    task automatic tick();
        int n, total, j, last;
        int e_on, e_col, e_step, e_busy, e_done;
        n = cyc + 1;
        if (m_play && (n - 1) > m_k + m_len * PER) begin
            m_hold = (m_len == 0) ? 0 : m_len - 1;
            m_play = 0;
        end
        if (rst_SEQ) begin
            m_play = 0;
            m_hold = 0;
        end else if (!m_play) begin
            if (start) begin
                m_play = 1;
                m_k    = n;
                m_len  = (seq_len > 16) ? 16 : int'(seq_len);
                m_data = seq_data;
            end
        end else if (abort && (n - 1) < m_k + m_len * PER) begin
            m_hold = (n - 1 - m_k) / PER;
            m_play = 0;
        end

        @(posedge clk);
        cyc = n;
        #1;

        e_on = 0; e_col = 0; e_busy = 0; e_done = 0; e_step = m_hold;
        if (m_play) begin
            total = m_len * PER;
            j     = n - m_k - 1;
            last  = (m_len == 0) ? 0 : m_len - 1;
            if (j >= 0 && j < total) begin
                e_busy = 1;
                e_step = j / PER;
                if ((j % PER) < ON_C) begin
                    e_on  = 1;
                    e_col = int'((m_data >> (2 * (j / PER))) & 32'd3);
                end
            end else if (j == total) begin
                e_busy = 1;
                e_done = 1;
                e_step = last;
            end else if (j > total) begin
                e_step = last;
            end
        end
        chk("led_on",     int'(led_on),     e_on);
        chk("led_colour", int'(led_colour), e_col);
        chk("step_idx",   int'(step_idx),   e_step);
        chk("busy",       int'(busy),       e_busy);
        chk("done",       int'(done),       e_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [31:0] d, input logic [4:0] l);
        seq_data = d;
        seq_len  = l;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int ncyc, cl;

        // Reset state
        rst_SEQ = 1'b1;
        run(2);
        rst_SEQ = 1'b0;
        run(2);

        // Basic playback of colours 0,1,2,3
        pulse_start(32'h000000E4, 5'd4);
        run(30);

        // Snapshot: pattern changes during step 0 must not show
        pulse_start(32'h000000E4, 5'd2);
        run(2);
        seq_data = 32'hFFFFFFFF;
        run(15);

        // Zero length: immediate done, no light
        pulse_start(32'h12345678, 5'd0);
        run(4);

        // Length 20 clamps to 16 steps of colour 3
        pulse_start(32'hFFFFFFFF, 5'd20);
        run(100);

        // Abort during step 1 lit phase, then replay from step 0
        pulse_start(32'h000000E4, 5'd4);
        run(8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(3);
        pulse_start(32'h000000E4, 5'd4);
        run(28);

        // Reset during an OFF gap, then reset together with start
        pulse_start(32'h0000001B, 5'd4);
        run(4);
        rst_SEQ = 1'b1;
        tick();
        rst_SEQ = 1'b0;
        run(3);
        rst_SEQ = 1'b1;
        start   = 1'b1;
        tick();
        rst_SEQ = 1'b0;
        start   = 1'b0;
        run(3);

        // Start and abort together in IDLE: start wins
        seq_data = 32'h00000039;
        seq_len  = 5'd3;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        run(22);

        // Extra start pulses while busy are ignored
        pulse_start(32'h0000002D, 5'd3);
        run(5);
        pulse_start(32'hFFFFFFFF, 5'd1);
        run(10);
        pulse_start(32'h00000000, 5'd9);
        run(8);

        // Randomized playbacks with sporadic start/abort/reset/pattern noise
        for (int r = 0; r < 25; r++) begin
            pulse_start($urandom, 5'($urandom_range(0, 20)));
            cl   = (m_len > 0) ? m_len : 1;
            ncyc = cl * PER + 3 + int'($urandom_range(0, 3));
            for (int i = 0; i < ncyc; i++) begin
                start   = ($urandom_range(0, 19) == 0);
                abort   = ($urandom_range(0, 149) == 0);
                rst_SEQ = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 9) == 0) seq_data = $urandom;
                seq_len = 5'($urandom_range(0, 31));
                tick();
            end
            start   = 1'b0;
            abort   = 1'b0;
            rst_SEQ = 1'b0;
            run(3);
        end
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Playback stage directly downstream of the 32-bit pattern register, driven by its MEM_OUT word.
- Treats the word as 16 packed 2-bit colour codes; step i uses bits [2i+1:2i].
- On a start request, shows the first seq_len colours one at a time on the LED driver outputs, with programmable on and off (gap) times.
- Signals completion to the game controller.

Parameters:
- ON_CYCLES, 1000, clock cycles each colour is lit (legal range >= 1).
- OFF_CYCLES, 500, clock cycles of dark gap after each colour (legal range >= 1).
- CNT_W, 24, width of the internal timer; must hold max(ON_CYCLES, OFF_CYCLES) - 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_SEQ  in  1  synchronous, active-high reset.
- start  in  1  request playback; sampled only in IDLE.
- abort  in  1  stop playback immediately; no done pulse.
- seq_len  in  5  number of steps to play (0..16; values > 16 clamp to 16).
- seq_data  in  32  packed colour pattern (from MEM_OUT).
- led_on  out  1  high while a colour is lit.
- led_colour  out  2  colour code of the current step; 0 when not lit.
- step_idx  out  4  index of the current step.
- busy  out  1  high in ON, OFF and DONE.
- done  out  1  one-cycle pulse at end of a complete playback.

Interface decision (fixed): one clock, clk; reset rst_SEQ is synchronous and active-high.

Behaviour:
- Reset: on any rising edge with rst_SEQ=1, the block goes to IDLE. All outputs are 0, the timer is 0, and the snapshots are cleared. Reset takes priority over start and abort, including mid-playback.
- States: IDLE, ON, OFF, DONE.
- Snapshot on start: when start=1 in IDLE, seq_data and the clamped seq_len are captured into internal registers. Changes to the inputs during playback have no effect.
- IDLE with start=1 and clamped len >= 1:
  - Next state is ON, with step_idx=0 and timer loaded with ON_CYCLES-1.
- IDLE with start=1 and len=0:
  - Next state is DONE; no LED activity.
- ON:
  - led_on=1; led_colour = snapshot[2*step_idx+1 : 2*step_idx].
  - Timer decrements each cycle.
  - When timer=0, go to OFF with timer loaded with OFF_CYCLES-1.
  - Each step is lit for exactly ON_CYCLES cycles.
- OFF:
  - led_on=0, led_colour=0.
  - When timer=0 and step_idx=len-1, go to DONE.
  - When timer=0 otherwise, increment step_idx, load ON_CYCLES-1 and go to ON.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - step_idx holds its last value until the next start.
- Latency: start sampled at edge k. The first lit cycle follows edge k+1. done is high in the cycle after edge k+1+len*(ON_CYCLES+OFF_CYCLES).
- abort: in ON or OFF, the next edge goes to IDLE, with led_on=0 and no done pulse. In IDLE or DONE, abort is ignored; a DONE pulse still completes.
- start while busy: ignored, with no restart.
- start and abort together in IDLE: start wins; abort is evaluated from the next cycle.
- busy is high in ON, OFF and DONE, and low only in IDLE.
- step_idx wrap: step_idx never exceeds 15. Length 16 ends after step 15's OFF, with no wrap to 0.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {IDLE, ON, OFF, DONE};
  - COLOUR_W=2;
  - MAX_STEPS=16;
  - colour code constants (e.g. RED=0, GREEN=1, BLUE=2, YELLOW=3), also used by the input decoder.
- One natural sub-module: seq_timer, a CNT_W-bit down-counter with load, load value, and a zero flag.
- The FSM lives in seq_player.

Test Plan:
All scenarios use ON_CYCLES=4 and OFF_CYCLES=2.
- Basic playback: seq_data=32'h000000E4, seq_len=4, start pulse at edge k.
  - led_colour is 0,1,2,3, each lit 4 cycles with 2 dark cycles after it.
  - done is high only in the cycle after edge k+25.
  - busy is high in the cycles after edges k+1 through k+25.
- Snapshot: start with seq_data=32'h000000E4, seq_len=2, then change seq_data to 32'hFFFFFFFF during step 0.
  - Colours stay 0 then 1.
- Zero and clamp:
  - seq_len=0 gives a done pulse in the cycle after edge k+1, with led_on never high.
  - seq_len=20 with seq_data=32'hFFFFFFFF plays 16 steps of colour 3, and done follows edge k+97.
- Abort: abort during step 1's ON.
  - The block is in IDLE after the next edge, with led_on=0 and done never pulsed.
  - A subsequent start replays from step 0.
- Reset mid-op: rst_SEQ=1 for one cycle during an OFF gap.
  - After that edge, all outputs are 0 and the state is IDLE.
  - Simultaneous rst_SEQ and start leaves the block in IDLE.
- Busy start: a second start pulse during playback has no effect on the colour sequence or done timing.
